// File: rtl/dds_port_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dds_port_responder
//  Description : Responder (target) end of the DDS parallel port. Assembles
//                4-byte write words into a shadow register and commits them to
//                an active register on IO-update. Serialises the active
//                register onto the read bus for read transactions. All port
//                inputs are resynchronised into the clk domain.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rstn        responder clock, asynchronous active-low reset
//    dds_pclk         port clock; a beat is its rising edge while CSn is low
//    dds_ioup         IO-update; its rising edge commits shadow -> active
//    dds_csn          chip select, active low
//    dds_rwn          1 = read beat, 0 = write beat
//    dds_readen       master read enable (gates the read-bus drive)
//    dds_data_in      write byte from the master
//    dds_data_out     read byte to the master
//    dds_data_oe      read-bus drive enable
//    shadow_word      staged write word
//    active_word      committed word (source of read data)
//    update_pulse     one-clk pulse when active_word is loaded
//    word_done        one-clk pulse after the 4th write beat
//    beat_err         sticky protocol error flag
//    err_clr          clears beat_err (a same-cycle new error wins)
// ============================================================================
module dds_port_responder #(
  parameter int          SYNC_STAGES = 2,
  parameter int          GAP_TIMEOUT = 64,
  parameter logic [31:0] RESET_WORD  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        dds_pclk,
  input  logic        dds_ioup,
  input  logic        dds_csn,
  input  logic        dds_rwn,
  input  logic        dds_readen,
  input  logic [7:0]  dds_data_in,
  output logic [7:0]  dds_data_out,
  output logic        dds_data_oe,
  output logic [31:0] shadow_word,
  output logic [31:0] active_word,
  output logic        update_pulse,
  output logic        word_done,
  output logic        beat_err,
  input  logic        err_clr
);

  localparam int                  c_GAP_W    = $clog2(GAP_TIMEOUT + 1);
  localparam logic [c_GAP_W-1:0]  c_GAP_MAX  = c_GAP_W'(GAP_TIMEOUT);
  localparam int                  c_SYNC_W   = 13;
  // Bundle order: {pclk, ioup, csn, rwn, readen, data[7:0]}.
  // CSn resets high so release from reset is never seen as a select edge.
  localparam logic [c_SYNC_W-1:0] c_SYNC_RST = 13'b0_0_1_0_0_0000_0000;

  // --------------------------------------------------------------------------
  // Input synchroniser: data travels with the strobes through the same
  // number of stages so a byte stays aligned with its PCLK edge.
  // --------------------------------------------------------------------------
  logic [c_SYNC_W-1:0]                  w_async;
  logic [SYNC_STAGES-1:0][c_SYNC_W-1:0] r_sync;
  logic [c_SYNC_W-1:0]                  w_sync;

  assign w_async = {dds_pclk, dds_ioup, dds_csn, dds_rwn, dds_readen, dds_data_in};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_sync <= {SYNC_STAGES{c_SYNC_RST}};
    else       r_sync <= {r_sync[SYNC_STAGES-2:0], w_async};
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

  logic       w_pclk, w_ioup, w_csn, w_rwn, w_readen;
  logic [7:0] w_data;

  assign w_pclk   = w_sync[12];
  assign w_ioup   = w_sync[11];
  assign w_csn    = w_sync[10];
  assign w_rwn    = w_sync[9];
  assign w_readen = w_sync[8];
  assign w_data   = w_sync[7:0];

  // --------------------------------------------------------------------------
  // Edge detection on the synchronised strobes
  // --------------------------------------------------------------------------
  logic r_pclk_prev, r_csn_prev, r_ioup_prev;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pclk_prev <= 1'b0;
      r_csn_prev  <= 1'b1;
      r_ioup_prev <= 1'b0;
    end else begin
      r_pclk_prev <= w_pclk;
      r_csn_prev  <= w_csn;
      r_ioup_prev <= w_ioup;
    end
  end

  logic w_beat, w_wr_beat, w_rd_beat, w_csn_fall, w_ioup_rise;

  assign w_beat      = w_pclk & ~r_pclk_prev & ~w_csn;
  assign w_wr_beat   = w_beat & ~w_rwn;
  assign w_rd_beat   = w_beat &  w_rwn;
  assign w_csn_fall  = r_csn_prev & ~w_csn;
  assign w_ioup_rise = w_ioup & ~r_ioup_prev;

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  logic [1:0]         r_beat_cnt;
  logic [c_GAP_W-1:0] r_gap_cnt;
  logic [31:0]        r_shadow;
  logic [31:0]        r_active;
  logic [7:0]         r_data_out;
  logic               r_oe;
  logic               r_update_pulse;
  logic               r_word_done;
  logic               r_beat_err;

  function automatic logic [7:0] f_byte(input logic [31:0] word, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

  // Shadow including any write beat of this cycle; the IO-update commit
  // samples this so a beat and an update in the same cycle commit the new byte.
  logic [31:0] w_shadow_nxt;

  always_comb begin
    w_shadow_nxt = r_shadow;
    if (w_wr_beat) begin
      case (r_beat_cnt)
        2'd0:    w_shadow_nxt[31:24] = w_data;
        2'd1:    w_shadow_nxt[23:16] = w_data;
        2'd2:    w_shadow_nxt[15:8]  = w_data;
        default: w_shadow_nxt[7:0]   = w_data;
      endcase
    end
  end

  logic       w_gap_hit;
  logic [1:0] w_beat_cnt_nxt;
  logic       w_err_set;

  // A saturated gap counter keeps w_gap_hit asserted, but the beat counter
  // is cleared on the first hit so the error is raised only once.
  assign w_gap_hit      = w_csn && (r_gap_cnt == c_GAP_MAX) && (r_beat_cnt != 2'd0);
  assign w_beat_cnt_nxt = w_beat    ? r_beat_cnt + 2'd1 :
                          w_gap_hit ? 2'd0 : r_beat_cnt;
  assign w_err_set      = w_gap_hit || (w_ioup_rise && (w_beat_cnt_nxt != 2'd0));

  // Read data prefetch: byte 0 at select with no word in progress, then the
  // following byte after each read beat; after byte 3 the last byte is held.
  logic [7:0] w_data_out_nxt;

  always_comb begin
    w_data_out_nxt = r_data_out;
    if (w_rd_beat) begin
      if (r_beat_cnt != 2'd3) w_data_out_nxt = f_byte(r_active, r_beat_cnt + 2'd1);
    end else if (w_csn_fall && (r_beat_cnt == 2'd0)) begin
      w_data_out_nxt = f_byte(r_active, 2'd0);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_beat_cnt     <= 2'd0;
      r_gap_cnt      <= '0;
      r_shadow       <= RESET_WORD;
      r_active       <= RESET_WORD;
      r_data_out     <= 8'h00;
      r_oe           <= 1'b0;
      r_update_pulse <= 1'b0;
      r_word_done    <= 1'b0;
      r_beat_err     <= 1'b0;
    end else begin
      r_beat_cnt     <= w_beat_cnt_nxt;
      r_shadow       <= w_shadow_nxt;
      r_data_out     <= w_data_out_nxt;
      r_oe           <= w_readen & w_rwn & ~w_csn;
      r_update_pulse <= w_ioup_rise;
      r_word_done    <= w_wr_beat && (r_beat_cnt == 2'd3);

      if (!w_csn)                     r_gap_cnt <= '0;
      else if (r_gap_cnt != c_GAP_MAX) r_gap_cnt <= r_gap_cnt + c_GAP_W'(1);

      if (w_ioup_rise) r_active <= w_shadow_nxt;

      // A new error takes priority over a same-cycle clear.
      if (w_err_set)    r_beat_err <= 1'b1;
      else if (err_clr) r_beat_err <= 1'b0;
    end
  end

  assign dds_data_out = r_data_out;
  assign dds_data_oe  = r_oe;
  assign shadow_word  = r_shadow;
  assign active_word  = r_active;
  assign update_pulse = r_update_pulse;
  assign word_done    = r_word_done;
  assign beat_err     = r_beat_err;

endmodule
`default_nettype wire

// File: tb/tb_dds_port_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dds_port_responder
//  Description : Self-checking bench for dds_port_responder. A byte-level
//                model of the port (shadow/active words, word position,
//                sticky error) predicts every checked value.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dds_port_responder;

  localparam int          SYNC_STAGES = 2;
  localparam int          GAP_TIMEOUT = 64;
  localparam logic [31:0] RESET_WORD  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        dds_pclk = 1'b0;
  logic        dds_ioup = 1'b0;
  logic        dds_csn = 1'b1;
  logic        dds_rwn = 1'b0;
  logic        dds_readen = 1'b1;
  logic [7:0]  dds_data_in = 8'h00;
  logic [7:0]  dds_data_out;
  logic        dds_data_oe;
  logic [31:0] shadow_word;
  logic [31:0] active_word;
  logic        update_pulse;
  logic        word_done;
  logic        beat_err;
  logic        err_clr = 1'b0;

  always #5 clk = ~clk;

  dds_port_responder #(
    .SYNC_STAGES (SYNC_STAGES),
    .GAP_TIMEOUT (GAP_TIMEOUT),
    .RESET_WORD  (RESET_WORD)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .dds_pclk     (dds_pclk),
    .dds_ioup     (dds_ioup),
    .dds_csn      (dds_csn),
    .dds_rwn      (dds_rwn),
    .dds_readen   (dds_readen),
    .dds_data_in  (dds_data_in),
    .dds_data_out (dds_data_out),
    .dds_data_oe  (dds_data_oe),
    .shadow_word  (shadow_word),
    .active_word  (active_word),
    .update_pulse (update_pulse),
    .word_done    (word_done),
    .beat_err     (beat_err),
    .err_clr      (err_clr)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Pulse counters observed from the DUT outputs
  int wd_cnt = 0;
  int up_cnt = 0;
  always @(posedge clk) begin
    if (word_done)    wd_cnt <= wd_cnt + 1;
    if (update_pulse) up_cnt <= up_cnt + 1;
  end

  // Reference model
  logic [31:0] m_shadow;
  logic [31:0] m_active;
  int          m_beat;
  logic        m_err;
  int          exp_wd = 0;
  int          exp_up = 0;

  task automatic model_reset();
    m_shadow = RESET_WORD;
    m_active = RESET_WORD;
    m_beat   = 0;
    m_err    = 1'b0;
  endtask

  task automatic model_commit();
    if (m_beat != 0) m_err = 1'b1;
    m_active = m_shadow;
    exp_up++;
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One PCLK beat: data set up 4 clk before the rising edge, held 4 clk after.
  // The read byte is sampled just before the rising edge.
  task automatic do_beat(input logic [7:0] wbyte, input logic rd, input logic with_ioup,
                         output logic [7:0] rbyte, output logic roe);
    dds_data_in = wbyte;
    dds_rwn     = rd;
    wait_clk(4);
    rbyte = dds_data_out;
    roe   = dds_data_oe;
    dds_pclk = 1'b1;
    if (with_ioup) dds_ioup = 1'b1;
    wait_clk(4);
    dds_pclk = 1'b0;
    dds_ioup = 1'b0;
    wait_clk(3);
    if (!rd) begin
      m_shadow[8*(3-m_beat) +: 8] = wbyte;
      if (m_beat == 3) exp_wd++;
    end
    m_beat = (m_beat + 1) % 4;
    if (with_ioup) model_commit();
  endtask

  // n beats taken from w MSB first. mode 0: windows of 2 beats,
  // mode 1: random window breaks, mode 2: one window.
  task automatic xfer(input logic [31:0] w, input int n, input logic rd, input int mode,
                      input logic ioup_last, output logic [31:0] rword, output int oe_bad);
    logic       is_open;
    logic [7:0] rb;
    logic       ro;
    logic       brk;
    is_open = 1'b0;
    rword   = 32'h0;
    oe_bad  = 0;
    for (int k = 0; k < n; k++) begin
      if (!is_open) begin
        dds_rwn = rd;
        wait_clk(1);
        dds_csn = 1'b0;
        wait_clk(4);
        is_open = 1'b1;
      end
      do_beat(w[8*(3-k) +: 8], rd, ioup_last && (k == n-1), rb, ro);
      rword = {rword[23:0], rb};
      if (rd && ro !== 1'b1) oe_bad++;
      brk = (k == n-1) || (mode == 0 && (k % 2) == 1) ||
            (mode == 1 && $urandom_range(0, 1) == 1);
      if (brk) begin
        dds_csn = 1'b1;
        wait_clk(SYNC_STAGES + 3);
        if (dds_data_oe !== 1'b0) oe_bad++;
        is_open = 1'b0;
      end
    end
    dds_rwn = 1'b0;
  endtask

  task automatic pulse_ioup(input int width);
    dds_ioup = 1'b1;
    wait_clk(width);
    dds_ioup = 1'b0;
    wait_clk(SYNC_STAGES + 4);
    model_commit();
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    wait_clk(1);
    err_clr = 1'b0;
    wait_clk(2);
    m_err = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    model_reset();
    wait_clk(3);
    vectors++; if (shadow_word !== m_shadow) begin miscompares++; $display("FAIL reset_shadow: got %h want %h", shadow_word, m_shadow); end
    vectors++; if (active_word !== m_active) begin miscompares++; $display("FAIL reset_active: got %h want %h", active_word, m_active); end
    vectors++; if (dds_data_out !== 8'h00) begin miscompares++; $display("FAIL reset_data_out: got %h want 00", dds_data_out); end
    vectors++; if (dds_data_oe !== 1'b0) begin miscompares++; $display("FAIL reset_oe: got %b want 0", dds_data_oe); end
    vectors++; if ({beat_err, update_pulse, word_done} !== 3'b000) begin miscompares++; $display("FAIL reset_flags: got %b want 000", {beat_err, update_pulse, word_done}); end
    rstn = 1'b1;
    wait_clk(4);
  endtask

  task automatic test_write_commit();
    logic [31:0] rw; int ob; int wd0, up0;
    wd0 = wd_cnt; up0 = up_cnt;
    xfer(32'h1234_5678, 4, 1'b0, 0, 1'b0, rw, ob);
    vectors++; if (wd_cnt - wd0 !== 1) begin miscompares++; $display("FAIL wc_word_done: got %0d pulses want 1", wd_cnt - wd0); end
    vectors++; if (shadow_word !== m_shadow) begin miscompares++; $display("FAIL wc_shadow: got %h want %h", shadow_word, m_shadow); end
    pulse_ioup(3);
    vectors++; if (active_word !== m_active) begin miscompares++; $display("FAIL wc_active: got %h want %h", active_word, m_active); end
    vectors++; if (up_cnt - up0 !== 1) begin miscompares++; $display("FAIL wc_update_pulse: got %0d pulses want 1", up_cnt - up0); end
    vectors++; if (beat_err !== m_err) begin miscompares++; $display("FAIL wc_err: got %b want %b", beat_err, m_err); end
  endtask

  task automatic test_read();
    logic [31:0] rw; int ob;
    xfer(32'hA5C3_0F81, 4, 1'b0, 2, 1'b0, rw, ob);
    pulse_ioup(3);
    xfer(32'h0, 4, 1'b1, 0, 1'b0, rw, ob);
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (rw[8*(3-k) +: 8] !== m_active[8*(3-k) +: 8]) begin
        miscompares++;
        $display("FAIL read_byte%0d: got %h want %h", k, rw[8*(3-k) +: 8], m_active[8*(3-k) +: 8]);
      end
    end
    vectors++; if (ob !== 0) begin miscompares++; $display("FAIL read_oe: got %0d bad oe samples want 0", ob); end
    vectors++; if (shadow_word !== m_shadow) begin miscompares++; $display("FAIL read_shadow: got %h want %h", shadow_word, m_shadow); end
    vectors++; if (active_word !== m_active) begin miscompares++; $display("FAIL read_active: got %h want %h", active_word, m_active); end
  endtask

  task automatic test_write_no_update();
    logic [31:0] rw; int ob; int up0;
    up0 = up_cnt;
    xfer(32'hDEAD_BEEF, 4, 1'b0, 1, 1'b0, rw, ob);
    wait_clk(10);
    vectors++; if (shadow_word !== m_shadow) begin miscompares++; $display("FAIL nu_shadow: got %h want %h", shadow_word, m_shadow); end
    vectors++; if (active_word !== m_active) begin miscompares++; $display("FAIL nu_active: got %h want %h", active_word, m_active); end
    vectors++; if (up_cnt - up0 !== 0) begin miscompares++; $display("FAIL nu_update_pulse: got %0d pulses want 0", up_cnt - up0); end
  endtask

  task automatic test_partial_update();
    logic [31:0] rw; int ob; int wd0;
    xfer(32'h1122_0000, 2, 1'b0, 2, 1'b0, rw, ob);
    pulse_ioup(3);
    vectors++; if (beat_err !== m_err) begin miscompares++; $display("FAIL pu_err_set: got %b want %b", beat_err, m_err); end
    vectors++; if (active_word !== m_active) begin miscompares++; $display("FAIL pu_active: got %h want %h", active_word, m_active); end
    pulse_err_clr();
    vectors++; if (beat_err !== m_err) begin miscompares++; $display("FAIL pu_err_clr: got %b want %b", beat_err, m_err); end
    wd0 = wd_cnt;
    xfer(32'h3344_0000, 2, 1'b0, 2, 1'b0, rw, ob);
    vectors++; if (wd_cnt - wd0 !== 1) begin miscompares++; $display("FAIL pu_word_done: got %0d pulses want 1", wd_cnt - wd0); end
    vectors++; if (shadow_word !== m_shadow) begin miscompares++; $display("FAIL pu_shadow: got %h want %h", shadow_word, m_shadow); end
  endtask

  task automatic test_gap_timeout();
    logic [31:0] rw; int ob;
    xfer(32'hABCD_0000, 2, 1'b0, 2, 1'b0, rw, ob);
    wait_clk(GAP_TIMEOUT + 2);
    if (m_beat != 0) m_err = 1'b1;
    m_beat = 0;
    vectors++; if (beat_err !== m_err) begin miscompares++; $display("FAIL gap_err: got %b want %b", beat_err, m_err); end
    xfer(32'hCAFE_F00D, 4, 1'b0, 0, 1'b0, rw, ob);
    pulse_ioup(3);
    vectors++; if (active_word !== m_active) begin miscompares++; $display("FAIL gap_active: got %h want %h", active_word, m_active); end
    vectors++; if (beat_err !== m_err) begin miscompares++; $display("FAIL gap_err_hold: got %b want %b", beat_err, m_err); end
  endtask

  // err_clr arrives in the same clk as an IO-update error; the error must win.
  task automatic test_err_race();
    logic [31:0] rw; int ob; int wd0;
    pulse_err_clr();
    xfer(32'h5A00_0000, 1, 1'b0, 2, 1'b0, rw, ob);
    dds_ioup = 1'b1;
    wait_clk(SYNC_STAGES);
    err_clr = 1'b1;
    wait_clk(1);
    err_clr = 1'b0;
    wait_clk(3);
    dds_ioup = 1'b0;
    wait_clk(SYNC_STAGES + 4);
    model_commit();
    vectors++; if (beat_err !== m_err) begin miscompares++; $display("FAIL race_err: got %b want %b", beat_err, m_err); end
    vectors++; if (active_word !== m_active) begin miscompares++; $display("FAIL race_active: got %h want %h", active_word, m_active); end
    wd0 = wd_cnt;
    xfer(32'h6B7C_8D00, 3, 1'b0, 1, 1'b0, rw, ob);
    vectors++; if (wd_cnt - wd0 !== 1) begin miscompares++; $display("FAIL race_word_done: got %0d pulses want 1", wd_cnt - wd0); end
  endtask

  // Last write beat and IO-update edge in the same clk, then a long IO-update.
  task automatic test_back_to_back();
    logic [31:0] rw; int ob; int up0;
    pulse_err_clr();
    up0 = up_cnt;
    xfer(32'h1357_9BDF, 4, 1'b0, 0, 1'b1, rw, ob);
    wait_clk(SYNC_STAGES + 4);
    vectors++; if (active_word !== m_active) begin miscompares++; $display("FAIL b2b_active: got %h want %h", active_word, m_active); end
    vectors++; if (beat_err !== m_err) begin miscompares++; $display("FAIL b2b_err: got %b want %b", beat_err, m_err); end
    vectors++; if (up_cnt - up0 !== 1) begin miscompares++; $display("FAIL b2b_update_pulse: got %0d pulses want 1", up_cnt - up0); end
    up0 = up_cnt;
    pulse_ioup(20);
    vectors++; if (up_cnt - up0 !== 1) begin miscompares++; $display("FAIL long_ioup_pulses: got %0d pulses want 1", up_cnt - up0); end
  endtask

  task automatic test_reset_midword();
    logic [31:0] rw; int ob;
    xfer(32'h7788_0000, 2, 1'b0, 2, 1'b0, rw, ob);
    rstn = 1'b0;
    wait_clk(2);
    model_reset();
    vectors++; if (shadow_word !== m_shadow) begin miscompares++; $display("FAIL rst_shadow: got %h want %h", shadow_word, m_shadow); end
    vectors++; if (active_word !== m_active) begin miscompares++; $display("FAIL rst_active: got %h want %h", active_word, m_active); end
    vectors++; if ({dds_data_out, dds_data_oe, beat_err} !== 10'h0) begin miscompares++; $display("FAIL rst_outputs: got %h want 000", {dds_data_out, dds_data_oe, beat_err}); end
    rstn = 1'b1;
    wait_clk(4);
    xfer(32'h0102_0304, 4, 1'b0, 0, 1'b0, rw, ob);
    pulse_ioup(3);
    vectors++; if (active_word !== m_active) begin miscompares++; $display("FAIL rst_commit: got %h want %h", active_word, m_active); end
    vectors++; if (beat_err !== m_err) begin miscompares++; $display("FAIL rst_err: got %b want %b", beat_err, m_err); end
  endtask

  task automatic test_random();
    logic [31:0] rw; int ob; int op;
    logic [31:0] w;
    for (int i = 0; i < 30; i++) begin
      op = $urandom_range(0, 3);
      w  = $urandom;
      case (op)
        0: xfer(w, 4, 1'b0, 1, 1'b0, rw, ob);
        1: xfer(w, 4, 1'b0, 0, ($urandom_range(0, 1) == 1), rw, ob);
        2: pulse_ioup($urandom_range(1, 8));
        default: begin
          xfer(32'h0, 4, 1'b1, 1, 1'b0, rw, ob);
          vectors++; if (rw !== m_active) begin miscompares++; $display("FAIL rnd_read[%0d]: got %h want %h", i, rw, m_active); end
          vectors++; if (ob !== 0) begin miscompares++; $display("FAIL rnd_oe[%0d]: got %0d bad samples want 0", i, ob); end
        end
      endcase
      wait_clk(SYNC_STAGES + 2);
      vectors++; if (shadow_word !== m_shadow) begin miscompares++; $display("FAIL rnd_shadow[%0d]: got %h want %h", i, shadow_word, m_shadow); end
      vectors++; if (active_word !== m_active) begin miscompares++; $display("FAIL rnd_active[%0d]: got %h want %h", i, active_word, m_active); end
      vectors++; if (beat_err !== m_err) begin miscompares++; $display("FAIL rnd_err[%0d]: got %b want %b", i, beat_err, m_err); end
      vectors++; if (wd_cnt !== exp_wd) begin miscompares++; $display("FAIL rnd_word_done[%0d]: got %0d want %0d", i, wd_cnt, exp_wd); end
      vectors++; if (up_cnt !== exp_up) begin miscompares++; $display("FAIL rnd_update[%0d]: got %0d want %0d", i, up_cnt, exp_up); end
    end
  endtask

  initial begin
    test_reset();
    test_write_commit();
    test_read();
    test_write_no_update();
    test_partial_update();
    test_gap_timeout();
    test_err_race();
    test_back_to_back();
    test_reset_midword();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
